// File: rtl/alu_operand_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_loader_if
//  Description : Operand/opcode bus between a producer and alu_operand_loader,
//                plus the registered operand outputs that feed the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_loader_if #(
    parameter int WIDTH = 8
);
    logic                    data_in_dummy_unused_guard;
    logic [WIDTH-1:0]        data_in;
    logic                    data_valid;
    logic                    next;
    logic                    clear;
    logic signed [WIDTH-1:0] in1;
    logic signed [WIDTH-1:0] in2;
    logic [1:0]              op;
    logic                    invalid_data;
    logic                    operands_valid;
    logic                    timeout;
    logic [1:0]              state;

    // Producer / consumer side
    modport master (
        output data_in, data_valid, next, clear,
        input  in1, in2, op, invalid_data, operands_valid, timeout, state
    );

    // Loader side
    modport slave (
        input  data_in, data_valid, next, clear,
        output in1, in2, op, invalid_data, operands_valid, timeout, state
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_loader
//  Description : Collects in1, in2 and a 2-bit opcode from a shared strobed
//                bus, presents them as registered operands to the ALU and
//                holds them until the consumer signals next.
//                Optional watchdog enabled by defining LOADER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_loader #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_operand_loader_if.slave bus
);

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_OP    = 2'd2,
        S_READY = 2'd3
    } state_t;

    state_t                  r_state;
    logic signed [WIDTH-1:0] r_in1;
    logic signed [WIDTH-1:0] r_in2;
    logic [1:0]              r_op;
    logic                    r_op_bad;
    logic                    r_operands_valid;
    logic                    r_invalid_data;
    logic                    w_op_hi_set;

    // Any set bit above the 2-bit opcode field marks the opcode as malformed
    assign w_op_hi_set = |bus.data_in[WIDTH-1:2];

`ifdef LOADER_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
    logic [c_WD_W-1:0]            r_watchdog;
    logic                         r_timeout;
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    // Loader FSM with all outputs registered; rst beats clear beats strobes
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_state          <= S_A;
            r_in1            <= '0;
            r_in2            <= '0;
            r_op             <= '0;
            r_op_bad         <= 1'b0;
            r_operands_valid <= 1'b0;
            r_invalid_data   <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
            r_timeout        <= 1'b0;
            r_watchdog       <= '0;
`endif
        end else begin
            case (r_state)
                S_A: begin
                    if (bus.data_valid) begin
                        r_in1   <= bus.data_in;
                        r_state <= S_B;
`ifdef LOADER_TIMEOUT_EN
                        r_timeout  <= 1'b0;
                        r_watchdog <= '0;
`endif
                    end
                end
                S_B: begin
                    if (bus.data_valid) begin
                        r_in2   <= bus.data_in;
                        r_state <= S_OP;
`ifdef LOADER_TIMEOUT_EN
                        r_watchdog <= '0;
                    end else if (r_watchdog == c_WD_LAST) begin
                        // Give up waiting: present what we have, flagged bad
                        r_state          <= S_READY;
                        r_timeout        <= 1'b1;
                        r_operands_valid <= 1'b1;
                        r_invalid_data   <= 1'b1;
                        r_watchdog       <= '0;
                    end else begin
                        r_watchdog <= r_watchdog + c_WD_W'(1);
`endif
                    end
                end
                S_OP: begin
                    if (bus.data_valid) begin
                        r_op             <= bus.data_in[1:0];
                        r_op_bad         <= w_op_hi_set;
                        r_state          <= S_READY;
                        r_operands_valid <= 1'b1;
                        r_invalid_data   <= w_op_hi_set;
`ifdef LOADER_TIMEOUT_EN
                        r_watchdog <= '0;
                    end else if (r_watchdog == c_WD_LAST) begin
                        r_state          <= S_READY;
                        r_timeout        <= 1'b1;
                        r_operands_valid <= 1'b1;
                        r_invalid_data   <= 1'b1;
                        r_watchdog       <= '0;
                    end else begin
                        r_watchdog <= r_watchdog + c_WD_W'(1);
`endif
                    end
                end
                S_READY: begin
                    // Operands are kept until overwritten; strobes here are dropped
                    if (bus.next) begin
                        r_state          <= S_A;
                        r_op_bad         <= 1'b0;
                        r_operands_valid <= 1'b0;
                        r_invalid_data   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_A;
                end
            endcase
        end
    end

    assign bus.in1            = r_in1;
    assign bus.in2            = r_in2;
    assign bus.op             = r_op;
    assign bus.invalid_data   = r_invalid_data;
    assign bus.operands_valid = r_operands_valid;
    assign bus.state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_loader
//  Description : Self-checking bench for alu_operand_loader with a scoreboard
//                of expected operand sets popped when operands_valid rises.
//                Define LOADER_TIMEOUT_EN to exercise the watchdog build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

    localparam int c_WIDTH = 8;
    localparam int c_TMO   = 4;

    typedef struct packed {
        logic [7:0] in1;
        logic [7:0] in2;
        logic [1:0] op;
        logic       inv;
        logic       tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic r_prev_ov = 1'b0;

    always #5 clk = ~clk;

    alu_operand_loader_if #(.WIDTH(c_WIDTH)) bus ();

    alu_operand_loader #(
        .WIDTH          (c_WIDTH),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Count one comparison and report it when it does not hold
    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus, applied at the falling edge
    task automatic drive_cycle(input logic nx, input logic cl, input logic dv, input logic [7:0] v);
        @(negedge clk);
        bus.next       = nx;
        bus.clear      = cl;
        bus.data_valid = dv;
        bus.data_in    = v;
        @(negedge clk);
        bus.next       = 1'b0;
        bus.clear      = 1'b0;
        bus.data_valid = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] v);
        drive_cycle(1'b0, 1'b0, 1'b1, v);
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                            input logic inv, input logic tmo);
        exp_t e;
        e.in1 = a; e.in2 = b; e.op = o; e.inv = inv; e.tmo = tmo;
        sb_q.push_back(e);
    endtask

    // Scoreboard: on each operands_valid rise, pop and compare one set
    always @(negedge clk) begin
        if (bus.operands_valid && !r_prev_ov) begin
            check_value("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_value("sb_in1", 32'($unsigned(bus.in1)), 32'(e.in1));
                check_value("sb_in2", 32'($unsigned(bus.in2)), 32'(e.in2));
                check_value("sb_op",  32'(bus.op),           32'(e.op));
                check_value("sb_inv", 32'(bus.invalid_data), 32'(e.inv));
                check_value("sb_tmo", 32'(bus.timeout),      32'(e.tmo));
            end
        end
        r_prev_ov = bus.operands_valid;
    end

    task automatic check_reset_values(input string pfx);
        check_value({pfx, "_state"}, 32'(bus.state),          32'd0);
        check_value({pfx, "_in1"},   32'($unsigned(bus.in1)), 32'd0);
        check_value({pfx, "_in2"},   32'($unsigned(bus.in2)), 32'd0);
        check_value({pfx, "_op"},    32'(bus.op),             32'd0);
        check_value({pfx, "_ov"},    32'(bus.operands_valid), 32'd0);
        check_value({pfx, "_inv"},   32'(bus.invalid_data),   32'd1);
        check_value({pfx, "_tmo"},   32'(bus.timeout),        32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: observed=expired required=finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.next       = 1'b0;
        bus.clear      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst");

        // Clean transaction: 5, -3, add-type opcode 2
        push_exp(8'h05, 8'hFD, 2'd2, 1'b0, 1'b0);
        strobe(8'h05);
        check_value("a_state", 32'(bus.state), 32'd1);
        check_value("a_in1",   32'($unsigned(bus.in1)), 32'h05);
        check_value("a_inv",   32'(bus.invalid_data), 32'd1);
        strobe(8'hFD);
        check_value("b_state", 32'(bus.state), 32'd2);
        check_value("b_ov",    32'(bus.operands_valid), 32'd0);
        strobe(8'h02);
        check_value("op_state", 32'(bus.state), 32'd3);
        check_value("op_ov",    32'(bus.operands_valid), 32'd1);
        check_value("op_inv",   32'(bus.invalid_data), 32'd0);

        // Strobes in S_READY are ignored
        strobe(8'h33);
        check_value("rdy_hold_state", 32'(bus.state), 32'd3);
        check_value("rdy_hold_in1",   32'($unsigned(bus.in1)), 32'h05);

        // next with data_valid in S_READY: return to S_A, data dropped
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h44);
        check_value("nxdv_state", 32'(bus.state), 32'd0);
        check_value("nxdv_in1",   32'($unsigned(bus.in1)), 32'h05);
        check_value("nxdv_in2",   32'($unsigned(bus.in2)), 32'hFD);
        check_value("nxdv_ov",    32'(bus.operands_valid), 32'd0);
        check_value("nxdv_inv",   32'(bus.invalid_data), 32'd1);

        // Malformed opcode 0x07 -> op=3 but flagged invalid
        push_exp(8'h01, 8'h02, 2'd3, 1'b1, 1'b0);
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h07);
        check_value("bad_op",  32'(bus.op), 32'd3);
        check_value("bad_inv", 32'(bus.invalid_data), 32'd1);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);

        // next in S_B is ignored; clear with data_valid in S_B aborts
        strobe(8'h10);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check_value("nx_sb_state", 32'(bus.state), 32'd1);
        drive_cycle(1'b0, 1'b1, 1'b1, 8'h22);
        check_value("clr_state", 32'(bus.state), 32'd0);
        check_value("clr_in1",   32'($unsigned(bus.in1)), 32'd0);
        check_value("clr_in2",   32'($unsigned(bus.in2)), 32'd0);
        check_value("clr_op",    32'(bus.op), 32'd0);

        // One strobe then idle: watchdog build times out after 4 idle cycles
`ifdef LOADER_TIMEOUT_EN
        push_exp(8'h09, 8'h00, 2'd0, 1'b1, 1'b1);
`endif
        strobe(8'h09);
        check_value("wd_start_state", 32'(bus.state), 32'd1);
        repeat (3) @(negedge clk);
        check_value("wd_not_early", 32'(bus.state), 32'd1);
        @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
        check_value("wd_state", 32'(bus.state), 32'd3);
        check_value("wd_tmo",   32'(bus.timeout), 32'd1);
        check_value("wd_inv",   32'(bus.invalid_data), 32'd1);
        check_value("wd_in1",   32'($unsigned(bus.in1)), 32'h09);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
`else
        repeat (8) @(negedge clk);
        check_value("nowd_state", 32'(bus.state), 32'd1);
        check_value("nowd_tmo",   32'(bus.timeout), 32'd0);
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
`endif
        check_value("wd_exit_state", 32'(bus.state), 32'd0);

        // data_valid held high three cycles = three strobes
        push_exp(8'h7F, 8'h80, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h7F;
        @(negedge clk);
        bus.data_in    = 8'h80;
        @(negedge clk);
        bus.data_in    = 8'h00;
        @(negedge clk);
        bus.data_valid = 1'b0;
        check_value("held_state", 32'(bus.state), 32'd3);
        check_value("held_tmo",   32'(bus.timeout), 32'd0);

        // Reset mid-transaction in S_OP, with a simultaneous strobe
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        strobe(8'h11);
        strobe(8'h22);
        check_value("pre_rst_state", 32'(bus.state), 32'd2);
        @(negedge clk);
        rst            = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h01;
        @(negedge clk);
        rst            = 1'b0;
        bus.data_valid = 1'b0;
        check_reset_values("rst_sop");

        repeat (2) @(negedge clk);
        check_value("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width, matching the downstream ALU WIDTH.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning idle cycles tolerated mid-transaction (used only with LOADER_TIMEOUT_EN).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, synchronous, active-high.
REQ-005 The block SHALL have port data_in, input, WIDTH, meaning the shared operand/opcode bus, sampled only when data_valid=1.
REQ-006 The block SHALL have port data_valid, input, 1, meaning a one-cycle strobe qualifying data_in.
REQ-007 The block SHALL have port next, input, 1, meaning the consumer has used the operands and the block returns to S_A.
REQ-008 The block SHALL have port clear, input, 1, meaning a synchronous transaction abort.
REQ-009 The block SHALL have ports in1 and in2, output, WIDTH signed, meaning registered operands to the ALU.
REQ-010 The block SHALL have port op, output, 2, meaning the registered ALU opcode.
REQ-011 The block SHALL have port invalid_data, output, 1, meaning registered; drives the ALU invalid_data input.
REQ-012 The block SHALL have port operands_valid, output, 1, meaning in1/in2/op are complete and stable.
REQ-013 The block SHALL have port timeout, output, 1, meaning the last transaction ended by watchdog.
REQ-014 The block SHALL have port state, output, 2, meaning FSM encoding S_A=0, S_B=1, S_OP=2, S_READY=3.

Function
REQ-015 In S_A, data_valid=1 SHALL capture data_in into in1, clear timeout, and move to S_B next cycle.
REQ-016 In S_B, data_valid=1 SHALL capture data_in into in2 and move to S_OP.
REQ-017 In S_OP, data_valid=1 SHALL capture data_in[1:0] into op, set op_bad=1 if data_in[WIDTH-1:2]!=0, and move to S_READY.
REQ-018 In S_READY, the block SHALL hold all registers, ignore data_valid, and move to S_A on next=1.
REQ-019 operands_valid SHALL be 1 exactly while state=S_READY, asserting in the cycle after the opcode strobe (latency 1).
REQ-020 invalid_data SHALL be 1 in every state except S_READY, and in S_READY SHALL equal op_bad OR timeout, so the ALU outputs -1 until a clean operand set is present.
REQ-021 next=1 outside S_READY SHALL be ignored.
REQ-022 clear=1 SHALL, in any state, zero in1/in2/op/op_bad/timeout and move to S_A next cycle; clear SHALL win over simultaneous data_valid or next.
REQ-023 Simultaneous next and data_valid in S_READY SHALL move to S_A without capturing; that data is dropped.
REQ-024 Leaving S_READY via next SHALL keep in1/in2/op values until overwritten, and clear op_bad.
REQ-025 data_valid held high for N cycles SHALL be treated as N strobes, one field per cycle.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL set state=S_A, in1=0, in2=0, op=0, op_bad=0, timeout=0, operands_valid=0, invalid_data=1, watchdog=0.
REQ-027 rst SHALL take priority over clear, next and data_valid, including mid-transaction.

Configuration
REQ-028 With LOADER_TIMEOUT_EN defined, a watchdog SHALL count cycles without data_valid in S_B or S_OP, reset on each accepted strobe and on entry to S_B.
REQ-029 With LOADER_TIMEOUT_EN defined, on the count reaching TIMEOUT_CYCLES the block SHALL move to S_READY with timeout=1, invalid_data=1, and unloaded fields unchanged.
REQ-030 With LOADER_TIMEOUT_EN undefined, the block SHALL have no watchdog, SHALL tie timeout to 0, and SHALL wait indefinitely in S_B/S_OP.

Verification
REQ-031 Bench SHALL cover: WIDTH=8, strobes 0x05, 0xFD, 0x02 -> in1=5, in2=-3, op=2, operands_valid=1, invalid_data=0 one cycle after the third strobe.
REQ-032 Bench SHALL cover: opcode strobe 0x07 -> op=3, invalid_data=1 in S_READY.
REQ-033 Bench SHALL cover: clear asserted with data_valid in S_B -> state=S_A, in1=0, in2 not captured.
REQ-034 Bench SHALL cover: next with data_valid in S_READY -> S_A, data dropped; next in S_B -> ignored.
REQ-035 Bench SHALL cover: LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=4, one strobe then idle -> S_READY with timeout=1 after 4 idle cycles; macro undefined -> remains in S_B.
REQ-036 Bench SHALL cover: rst in S_OP -> all REQ-026 values in the next cycle.
